// File: rtl/fpu_mul_pipe_ctl_if.sv
// Request/result handshake bundle for the FP multiply pipe controller.
// master = requester and result consumer, slave = pipe controller.
interface fpu_mul_pipe_ctl_if;
    logic       inq_mul_req;
    logic [4:0] inq_id;
    logic       inq_dbl;
    logic       mul_inq_ack;
    logic       mul_dest_rdy;
    logic       mul_res_vld;
    logic [4:0] mul_res_id;

    modport master (
        output inq_mul_req,
        output inq_id,
        output inq_dbl,
        output mul_dest_rdy,
        input  mul_inq_ack,
        input  mul_res_vld,
        input  mul_res_id
    );

    modport slave (
        input  inq_mul_req,
        input  inq_id,
        input  inq_dbl,
        input  mul_dest_rdy,
        output mul_inq_ack,
        output mul_res_vld,
        output mul_res_id
    );
endinterface

// File: rtl/fpu_mul_pipe_ctl.sv
// Six-stage FP multiply pipe control: stage valids/tags, stall, step selects.
// Define FPU_MUL_CLKGATE_EN to gate the datapath clock while the pipe is idle.
module fpu_mul_pipe_ctl (
    input  logic                     rclk,
    input  logic                     arst_l,
    fpu_mul_pipe_ctl_if.slave        mul_if,
    input  logic                     m4stg_denorm,
    input  logic                     m5stg_rnd_up,
    input  logic                     m5stg_in_of,
    output logic                     m6stg_step,
    output logic                     fmul_clken_l,
    output logic                     m4stg_left_shift_step,
    output logic                     m4stg_right_shift_step,
    output logic                     mul_frac_out_fracadd,
    output logic                     mul_frac_out_frac,
    output logic                     m5stg_fmuls,
    output logic                     m5stg_fmulda,
    output logic [2:0]               mul_pipe_cnt
);

    typedef struct packed {
        logic       vld;
        logic [4:0] id;
        logic       dbl;
    } stg_t;

    stg_t [6:1] stg_q;
    stg_t [6:1] stg_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       ack;
    logic       done;

    always_comb begin
        m6stg_step = ~stg_q[6].vld | mul_if.mul_dest_rdy;
        // Hold ack low while reset is applied so no request appears accepted.
        ack        = mul_if.inq_mul_req & m6stg_step & arst_l;
        done       = stg_q[6].vld & mul_if.mul_dest_rdy;
    end

    always_comb begin
        stg_d = stg_q;
        if (m6stg_step) begin
            stg_d[1].vld = ack;
            stg_d[1].id  = mul_if.inq_id;
            stg_d[1].dbl = mul_if.inq_dbl;
            for (int k = 2; k <= 6; k++) begin
                stg_d[k] = stg_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({ack, done})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            stg_q <= '0;
            cnt_q <= 3'd0;
        end else begin
            stg_q <= stg_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        mul_if.mul_inq_ack     = ack;
        mul_if.mul_res_vld     = stg_q[6].vld;
        mul_if.mul_res_id      = stg_q[6].id;
        mul_pipe_cnt           = cnt_q;
        m4stg_left_shift_step  = stg_q[4].vld & ~m4stg_denorm & m6stg_step;
        m4stg_right_shift_step = stg_q[4].vld &  m4stg_denorm & m6stg_step;
        m5stg_fmuls            = stg_q[5].vld & ~stg_q[5].dbl;
        m5stg_fmulda           = stg_q[5].vld &  stg_q[5].dbl;
        mul_frac_out_fracadd   = stg_q[5].vld &  m5stg_rnd_up & ~m5stg_in_of;
        mul_frac_out_frac      = stg_q[5].vld & ~m5stg_rnd_up & ~m5stg_in_of;
    end

`ifdef FPU_MUL_CLKGATE_EN
    assign fmul_clken_l = ~(mul_if.inq_mul_req | (cnt_q != 3'd0));
`else
    assign fmul_clken_l = 1'b0;
`endif

    a_cnt_range: assert property (
        @(posedge rclk) disable iff (!arst_l) cnt_q <= 3'd6);

    a_cnt_pop: assert property (
        @(posedge rclk) disable iff (!arst_l)
        32'(cnt_q) == $countones({stg_q[1].vld, stg_q[2].vld, stg_q[3].vld,
                                  stg_q[4].vld, stg_q[5].vld, stg_q[6].vld}));

    a_shift_excl: assert property (
        @(posedge rclk) disable iff (!arst_l)
        !(m4stg_left_shift_step && m4stg_right_shift_step));

    a_frac_excl: assert property (
        @(posedge rclk) disable iff (!arst_l)
        !(mul_frac_out_fracadd && mul_frac_out_frac));

endmodule

// File: doc/fpu_mul_pipe_ctl.md
FPU_MUL_PIPE_CTL -- requirements
Module: fpu_mul_pipe_ctl

Interface
REQ-001 SHALL have ports: rclk  in  1  global clock; arst_l  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: inq_mul_req  in  1  new multiply request valid; inq_id  in  5  request tag; inq_dbl  in  1  double-precision op.
REQ-003 SHALL have ports: mul_inq_ack  out  1  request accepted this cycle.
REQ-004 SHALL have ports: m4stg_denorm  in  1  stage-4 result needs right (denorm) shift; m5stg_rnd_up  in  1  stage-5 rounding increment; m5stg_in_of  in  1  stage-5 overflow.
REQ-005 SHALL have ports: mul_dest_rdy  in  1  result consumer ready.
REQ-006 SHALL have ports: m6stg_step  out  1  advance pipe; fmul_clken_l  out  1  datapath clock enable, active-low.
REQ-007 SHALL have ports: m4stg_left_shift_step  out  1; m4stg_right_shift_step  out  1; mul_frac_out_fracadd  out  1; mul_frac_out_frac  out  1; m5stg_fmuls  out  1; m5stg_fmulda  out  1.
REQ-008 SHALL have ports: mul_res_vld  out  1  result valid in stage 6; mul_res_id  out  5  result tag; mul_pipe_cnt  out  3  ops in flight (0-6).

Function
REQ-009 SHALL track six stage-valid bits m1..m6, with a 5-bit tag and a dbl bit per stage.
REQ-010 SHALL drive m6stg_step = ~m6_vld | mul_dest_rdy, combinationally.
REQ-011 SHALL drive mul_inq_ack = inq_mul_req & m6stg_step; an unacknowledged request is dropped by this block and the requester holds it.
REQ-012 SHALL, on a rising rclk edge with m6stg_step=1, load m1 <= {mul_inq_ack, inq_id, inq_dbl} and shift mK <= m(K-1) for K=2..6; with m6stg_step=0, all stages SHALL hold.
REQ-013 SHALL drive mul_res_vld = m6_vld and mul_res_id = m6 tag; a result completes on the cycle mul_res_vld & mul_dest_rdy.
REQ-014 SHALL have a latency of exactly 6 cycles from ack to mul_res_vld when there is no stall; sustained throughput SHALL be 1 op per cycle.
REQ-015 SHALL drive m4stg_left_shift_step = m4_vld & ~m4stg_denorm & m6stg_step, and m4stg_right_shift_step = m4_vld & m4stg_denorm & m6stg_step; the two SHALL never both be 1.
REQ-016 SHALL drive m5stg_fmuls = m5_vld & ~m5_dbl and m5stg_fmulda = m5_vld & m5_dbl.
REQ-017 SHALL drive mul_frac_out_fracadd = m5_vld & m5stg_rnd_up & ~m5stg_in_of and mul_frac_out_frac = m5_vld & ~m5stg_rnd_up & ~m5stg_in_of; the two SHALL be mutually exclusive.
REQ-018 SHALL keep mul_pipe_cnt equal to the popcount of m1..m6 valids, as a registered counter: +1 on ack without completion, -1 on completion without ack, unchanged when both or neither occur.
REQ-019 SHALL not allow the counter to wrap; a value above 6 is an assertion failure.
REQ-020 SHALL, during a stall with a full pipe (cnt=6), keep ack=0 and hold all stage contents and the count.

Reset
REQ-021 SHALL, while arst_l=0, asynchronously clear all valids, tags, dbl bits and mul_pipe_cnt; all outputs SHALL then be 0, except m6stg_step=1 and fmul_clken_l per REQ-023/024.
REQ-022 SHALL discard in-flight ops on a reset asserted mid-operation, with no result issued; the first ack after deassertion SHALL behave as from empty.

Configuration
REQ-023 SHALL, with FPU_MUL_CLKGATE_EN defined, drive fmul_clken_l = ~(inq_mul_req | (mul_pipe_cnt != 0)), gating the datapath clock while the pipe is idle.
REQ-024 SHALL, without FPU_MUL_CLKGATE_EN, tie fmul_clken_l to 0 (always enabled); all other behaviour SHALL be identical.

Verification
REQ-025 Single op: ack at cycle 0 with id=5'h0A, dbl=1 -> mul_res_vld=1 and id=0A at cycle 6; m5stg_fmulda=1 at cycle 5; cnt returns to 0.
REQ-026 Back-to-back: 6 reqs with ids 1..6 and mul_dest_rdy=1 -> results ids 1..6 on cycles 6..11; cnt peaks at 6.
REQ-027 Stall: fill pipe, then mul_dest_rdy=0 for 3 cycles -> m6stg_step=0, ack=0, stage contents frozen; results resume in order once rdy=1.
REQ-028 Shift and round selects: m4_vld with m4stg_denorm=1 -> right_shift_step=1 and left_shift_step=0; m5_vld with rnd_up=1 and in_of=1 -> fracadd=0 and frac=0.
REQ-029 Reset mid-flight: arst_l low with cnt=3 -> all valids and cnt=0 immediately; no mul_res_vld afterwards.
REQ-030 Clock gate: with FPU_MUL_CLKGATE_EN and an idle pipe -> fmul_clken_l=1; when inq_mul_req rises -> fmul_clken_l=0 in the same cycle.
